// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// Optional overflow output enabled by SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_cell.sv
// Full-subtractor cell built from two half subtractors and an OR.
// Used as the per-bit datapath of serial_subtractor.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);
  assign d  = a ^ b;
  assign bo = ~a & b;
endmodule

module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .a (a),
    .b (b),
    .d (d1),
    .bo(b1)
  );

  half_subtractor u_hs1 (
    .a (d1),
    .b (bin),
    .d (d),
    .bo(b2)
  );

  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             bf;
  logic             d;
  logic             bn;
  logic             accept;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  full_subtractor_cell u_cell (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bin (bf),
    .d   (d),
    .bout(bn)
  );

  // DONE is not busy, so a start there is accepted back-to-back
  assign accept = start && (state != SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      bf         <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      overflow   <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        state <= SHIFT;
        busy  <= 1'b1;
        a_sh  <= a;
        b_sh  <= b;
        bf    <= 1'b0;
        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
`endif
      end else if (state == SHIFT) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= {d, res_sh[WIDTH-1:1]};
        bf     <= bn;
        cnt    <= cnt + 1'b1;
        if (cnt == LAST) begin
          state      <= DONE;
          busy       <= 1'b0;
          done       <= 1'b1;
          diff       <= {d, res_sh[WIDTH-1:1]};
          borrow_out <= bn;
`ifdef SERIAL_SUB_OVF_EN
          overflow   <= (a_msb ^ b_msb) & (d ^ a_msb);
`endif
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Overflow checks compile in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         overflow;
`endif

  int checks = 0;
  int passed = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bo;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Drive one op; lat counts negedges from start edge until done is seen
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output logic [W-1:0] od, output logic obo,
                        output logic oov, output int lat);
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    od = diff;
    obo = borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    oov = overflow;
`else
    oov = 1'b0;
`endif
  endtask

  function automatic vec_t model(input logic [W-1:0] ia,
                                 input logic [W-1:0] ib);
    vec_t v;
    int sa;
    int sb;
    int sd;
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    sd = sa - sb;
    v.a = ia;
    v.b = ib;
    v.diff = W'((int'(ia) - int'(ib) + 256) % 256);
    v.bo = (int'(ia) < int'(ib));
    v.ovf = (sd > 127) || (sd < -128);
    return v;
  endfunction

  vec_t         tbl[7];
  vec_t         m;
  logic [W-1:0] rd;
  logic         rbo;
  logic         rov;
  int           lat;
  int           pulses;
  int           idx;

  initial begin
    tbl[0] = '{8'd100, 8'd37, 8'd63, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    tbl[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[6] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_bo", 32'(borrow_out), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(overflow), 0);
`endif
    rst = 1'b0;

    // Busy window: high for W cycles after the start edge
    @(negedge clk);
    a = 8'd100;
    b = 8'd37;
    start = 1'b1;
    for (int i = 1; i <= W + 1; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("busy_c%0d", i), 32'(busy), (i <= W) ? 1 : 0);
      chk($sformatf("done_c%0d", i), 32'(done), (i == W + 1) ? 1 : 0);
    end
    chk("t1_diff", 32'(diff), 63);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, rd, rbo, rov, lat);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), W + 1);
      chk($sformatf("tbl%0d_diff", i), 32'(rd), 32'(tbl[i].diff));
      chk($sformatf("tbl%0d_bo", i), 32'(rbo), 32'(tbl[i].bo));
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("tbl%0d_ovf", i), 32'(rov), 32'(tbl[i].ovf));
`endif
    end

    // Start while busy is ignored; diff held during the new shift
    @(negedge clk);
    a = 8'd50;
    b = 8'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'hEE;
    b = 8'h11;
    @(negedge clk);
    chk("t3_diff_held", 32'(diff), 32'(tbl[6].diff));
    @(negedge clk);
    a = 8'd1;
    b = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("t3_lat", 32'(lat), W + 1);
    chk("t3_diff", 32'(diff), 40);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("t3_no_extra", 32'(pulses), 0);

    // Reset in the middle of an operation
    @(negedge clk);
    a = 8'd200;
    b = 8'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_done", 32'(done), 0);
    chk("t4_diff", 32'(diff), 0);
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("t4_no_done", 32'(pulses), 0);
    run_op(8'd9, 8'd4, rd, rbo, rov, lat);
    chk("t4_lat", 32'(lat), W + 1);
    chk("t4_diff_after", 32'(rd), 5);

    // Start held high: back-to-back ops every W+1 cycles
    @(negedge clk);
    a = 8'd7;
    b = 8'd3;
    start = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        chk($sformatf("t5_at%0d", pulses), 32'(i), 32'((W + 1) * (pulses + 1)));
        chk($sformatf("t5_diff%0d", pulses), 32'(diff), 4);
        pulses++;
      end
    end
    start = 1'b0;
    chk("t5_pulses", 32'(pulses), 4);
    repeat (12) @(negedge clk);

    // Randomised operands against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      m = model(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      run_op(m.a, m.b, rd, rbo, rov, lat);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), W + 1);
      chk($sformatf("rnd%0d_diff", i), 32'(rd), 32'(m.diff));
      chk($sformatf("rnd%0d_bo", i), 32'(rbo), 32'(m.bo));
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("rnd%0d_ovf", i), 32'(rov), 32'(m.ovf));
`endif
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
